// File: rtl/reduce_pkg.sv
// Shared types for the serial mux-based reducer: operation codes, FSM states
// and the per-operation accumulator seed.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // AND-type reductions start from their identity 1, OR/XOR from 0.
  function automatic logic init_acc(input op_t op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/mux2.sv
// Basic 2:1 multiplexer, the only primitive the reduction datapath is built from.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/reduce_step.sv
// One accumulator update of the serial reduction, made purely of mux2 instances
// and constants; also flags when the accumulator hit its absorbing value.
module reduce_step
  import reduce_pkg::*;
(
  input  logic acc,
  input  logic data_bit,
  input  op_t  op,
  output logic next_acc,
  output logic absorbed
);

  logic n_acc, and_v, or_v, xor_v, lo_v, hi_v;
  logic n_next, abs_lo, abs_hi;

  mux2 u_not_acc (.a(1'b1),  .b(1'b0),  .sel(acc),      .y(n_acc));
  mux2 u_and     (.a(1'b0),  .b(acc),   .sel(data_bit), .y(and_v));
  mux2 u_or      (.a(acc),   .b(1'b1),  .sel(data_bit), .y(or_v));
  mux2 u_xor     (.a(acc),   .b(n_acc), .sel(data_bit), .y(xor_v));

  // NAND accumulates like AND; the inversion is applied at the output register.
  mux2 u_sel_lo  (.a(and_v), .b(or_v),  .sel(op[0]),    .y(lo_v));
  mux2 u_sel_hi  (.a(xor_v), .b(and_v), .sel(op[0]),    .y(hi_v));
  mux2 u_sel     (.a(lo_v),  .b(hi_v),  .sel(op[1]),    .y(next_acc));

  // Absorbing value: 0 for AND/NAND, 1 for OR, never for XOR.
  mux2 u_not_nxt (.a(1'b1),   .b(1'b0),     .sel(next_acc), .y(n_next));
  mux2 u_abs_lo  (.a(n_next), .b(next_acc), .sel(op[0]),    .y(abs_lo));
  mux2 u_abs_hi  (.a(1'b0),   .b(n_next),   .sel(op[0]),    .y(abs_hi));
  mux2 u_abs     (.a(abs_lo), .b(abs_hi),   .sel(op[1]),    .y(absorbed));

endmodule

// File: rtl/serial_reduce_using_mux.sv
// Serial WIDTH-bit reducer (AND/OR/XOR/NAND), one bit per clock LSB first,
// with valid/ready on both sides and optional early exit.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   BUSY  | shifting bits through the mux step
//   DONE  | result held on out_data until out_ready
module serial_reduce_using_mux
  import reduce_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_nxt;
  op_t                op_q;
  logic               acc, out_bit;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic               next_acc, absorbed, finish;

  reduce_step u_step (
    .acc      (acc),
    .data_bit (shreg[0]),
    .op       (op_q),
    .next_acc (next_acc),
    .absorbed (absorbed)
  );

  assign finish    = (cnt == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && absorbed);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_bit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      op_q    <= OP_AND;
      out_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            op_q  <= op_t'(in_op);
            acc   <= init_acc(op_t'(in_op));
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= next_acc;
          shreg <= shreg >> 1;
          cnt   <= cnt + CNT_W'(1);
          // Result is captured once so out_data stays frozen through DONE.
          if (finish) out_bit <= (op_q == OP_NAND) ? ~next_acc : next_acc;
        end
        default: ;
      endcase
    end
  end

endmodule
